// File: rtl/scr_wb_bridge_pkg.sv
// Shared types and default parameters for the multi-port core-to-Wishbone bridge.
package scr_wb_bridge_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } state_e;

   localparam int DEF_NPORT      = 2;
   localparam int DEF_AW         = 32;
   localparam int DEF_DW         = 32;
   localparam int DEF_TMO_CYCLES = 255;
   localparam int DEF_TMO_W      = 8;

   // Port-index width; a single port still needs a 1-bit index.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/scr_wb_mport_bridge_if.sv
// Core request channels plus Wishbone master signals of the bridge.
// Handshake: a port holds cpu_req_i until the one-cycle cpu_req_ack_o pulse; the bridge answers with one cpu_resp_vld_o pulse.
interface scr_wb_mport_bridge_if #(
   parameter int NPORT = 2,
   parameter int AW    = 32,
   parameter int DW    = 32
);
   localparam int SW = DW / 8;

   logic [NPORT-1:0]    cpu_req_i;
   logic [NPORT-1:0]    cpu_we_i;
   logic [NPORT*AW-1:0] cpu_adr_i;
   logic [NPORT*DW-1:0] cpu_wdata_i;
   logic [NPORT*SW-1:0] cpu_be_i;
   logic [NPORT-1:0]    cpu_req_ack_o;
   logic [NPORT-1:0]    cpu_resp_vld_o;
   logic                cpu_resp_err_o;
   logic [DW-1:0]       cpu_rdata_o;

   logic                wbd_cyc_o;
   logic                wbd_stb_o;
   logic                wbd_we_o;
   logic [AW-1:0]       wbd_adr_o;
   logic [DW-1:0]       wbd_dat_o;
   logic [SW-1:0]       wbd_sel_o;
   logic [DW-1:0]       wbd_dat_i;
   logic                wbd_ack_i;
   logic                wbd_err_i;
   logic                tmo_evt_o;

   // master: the bridge itself (Wishbone master, core-side responder)
   modport master (
      input  cpu_req_i, cpu_we_i, cpu_adr_i, cpu_wdata_i, cpu_be_i,
      input  wbd_dat_i, wbd_ack_i, wbd_err_i,
      output cpu_req_ack_o, cpu_resp_vld_o, cpu_resp_err_o, cpu_rdata_o,
      output wbd_cyc_o, wbd_stb_o, wbd_we_o, wbd_adr_o, wbd_dat_o, wbd_sel_o,
      output tmo_evt_o
   );

   // slave: the surrounding cores and Wishbone slave
   modport slave (
      output cpu_req_i, cpu_we_i, cpu_adr_i, cpu_wdata_i, cpu_be_i,
      output wbd_dat_i, wbd_ack_i, wbd_err_i,
      input  cpu_req_ack_o, cpu_resp_vld_o, cpu_resp_err_o, cpu_rdata_o,
      input  wbd_cyc_o, wbd_stb_o, wbd_we_o, wbd_adr_o, wbd_dat_o, wbd_sel_o,
      input  tmo_evt_o
   );

endinterface

// File: rtl/scr_rr_arb.sv
// Combinational round-robin arbiter: first requester strictly after the last grant wins.
module scr_rr_arb
   import scr_wb_bridge_pkg::*;
#(
   parameter  int NPORT = DEF_NPORT,
   localparam int IW    = idx_w(NPORT)
) (
   input  logic [NPORT-1:0] req,
   input  logic [IW-1:0]    last,
   output logic [NPORT-1:0] gnt,
   output logic [IW-1:0]    gnt_idx,
   output logic             req_any
);

   logic          found;
   logic [IW-1:0] p;

   // Scan from last+1 around to last itself, so the last winner has lowest priority.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      p       = '0;
      for (int i = 1; i <= NPORT; i++) begin
         p = IW'((int'(last) + i) % NPORT);
         if (!found && req[p]) begin
            found   = 1'b1;
            gnt[p]  = 1'b1;
            gnt_idx = p;
         end
      end
   end

   assign req_any = |req;

endmodule

// File: rtl/scr_wb_mport_bridge.sv
// N-port core request merger onto a single Wishbone master, one transfer outstanding, with bus timeout.
module scr_wb_mport_bridge
   import scr_wb_bridge_pkg::*;
#(
   parameter int NPORT      = DEF_NPORT,
   parameter int AW         = DEF_AW,
   parameter int DW         = DEF_DW,
   parameter int TMO_CYCLES = DEF_TMO_CYCLES,
   parameter int TMO_W      = DEF_TMO_W
) (
   input  logic                  wb_clk,
   input  logic                  wb_rst_n,
   scr_wb_mport_bridge_if.master bus,
   output state_e                dbg_state
);

   localparam int SW = DW / 8;
   localparam int IW = idx_w(NPORT);

   state_e           state;
   logic [IW-1:0]    rr_ptr;
   logic [IW-1:0]    gnt_idx;
   logic [NPORT-1:0] gnt;
   logic [NPORT-1:0] gnt_q;
   logic             req_any;
   logic [NPORT-1:0] req_ack;
   logic [NPORT-1:0] resp_vld;
   logic             resp_err;
   logic [DW-1:0]    rdata_q;
   logic             tmo_evt;
   logic [TMO_W-1:0] tmo_cnt;
   logic [TMO_W-1:0] tmo_nxt;
   logic             cyc;
   logic             we_q;
   logic [AW-1:0]    adr_q;
   logic [DW-1:0]    wdata_q;
   logic [SW-1:0]    sel_q;
   logic             term;
   logic             timed_out;

   scr_rr_arb #(.NPORT(NPORT)) u_arb (
      .req     (bus.cpu_req_i),
      .last    (rr_ptr),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .req_any (req_any)
   );

   assign tmo_nxt   = tmo_cnt + 1'b1;
   assign term      = bus.wbd_ack_i | bus.wbd_err_i;
   assign timed_out = (TMO_CYCLES != 0) && (tmo_nxt == TMO_W'(TMO_CYCLES));

   always_ff @(posedge wb_clk or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         state    <= IDLE;
         rr_ptr   <= IW'(NPORT - 1);
         gnt_q    <= '0;
         req_ack  <= '0;
         resp_vld <= '0;
         resp_err <= 1'b0;
         rdata_q  <= '0;
         tmo_evt  <= 1'b0;
         tmo_cnt  <= '0;
         cyc      <= 1'b0;
         we_q     <= 1'b0;
         adr_q    <= '0;
         wdata_q  <= '0;
         sel_q    <= '0;
      end else begin
         req_ack  <= '0;
         resp_vld <= '0;
         tmo_evt  <= 1'b0;
         case (state)
            IDLE: begin
               if (req_any) begin
                  gnt_q   <= gnt;
                  rr_ptr  <= gnt_idx;
                  req_ack <= gnt;
                  we_q    <= bus.cpu_we_i[gnt_idx];
                  adr_q   <= bus.cpu_adr_i[gnt_idx*AW +: AW];
                  wdata_q <= bus.cpu_wdata_i[gnt_idx*DW +: DW];
                  sel_q   <= bus.cpu_be_i[gnt_idx*SW +: SW];
                  cyc     <= 1'b1;
                  state   <= BUS;
               end
            end
            BUS: begin
               tmo_cnt <= tmo_nxt;
               // A real termination beats a timeout landing in the same cycle; err beats ack.
               if (term) begin
                  cyc      <= 1'b0;
                  resp_vld <= gnt_q;
                  resp_err <= bus.wbd_err_i;
                  rdata_q  <= (bus.wbd_err_i || we_q) ? '0 : bus.wbd_dat_i;
                  state    <= RESP;
               end else if (timed_out) begin
                  cyc      <= 1'b0;
                  resp_vld <= gnt_q;
                  resp_err <= 1'b1;
                  rdata_q  <= '0;
                  tmo_evt  <= 1'b1;
                  state    <= RESP;
               end
            end
            RESP: begin
               tmo_cnt <= '0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.cpu_req_ack_o  = req_ack;
   assign bus.cpu_resp_vld_o = resp_vld;
   assign bus.cpu_resp_err_o = resp_err;
   assign bus.cpu_rdata_o    = rdata_q;
   assign bus.wbd_cyc_o      = cyc;
   assign bus.wbd_stb_o      = cyc;
   assign bus.wbd_we_o       = we_q;
   assign bus.wbd_adr_o      = adr_q;
   assign bus.wbd_dat_o      = wdata_q;
   assign bus.wbd_sel_o      = sel_q;
   assign bus.tmo_evt_o      = tmo_evt;
   assign dbg_state          = state;

endmodule

// File: tb/tb_scr_wb_mport_bridge.sv
// Directed self-checking bench for scr_wb_mport_bridge (2 ports, 16-cycle timeout).
module tb_scr_wb_mport_bridge;
   import scr_wb_bridge_pkg::*;

   localparam int NPORT = 2;
   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int SW    = DW / 8;
   localparam int TMO   = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   scr_wb_mport_bridge_if #(.NPORT(NPORT), .AW(AW), .DW(DW)) bus ();
   state_e dbg_state;

   scr_wb_mport_bridge #(
      .NPORT(NPORT), .AW(AW), .DW(DW), .TMO_CYCLES(TMO), .TMO_W(8)
   ) dut (
      .wb_clk    (clk),
      .wb_rst_n  (rst_n),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // Wishbone slave model: optional zero-wait auto ack, manual ack/err, data fixed or derived from address.
   logic          auto_ack     = 1'b0;
   logic          man_ack      = 1'b0;
   logic          man_err      = 1'b0;
   logic          dat_from_adr = 1'b0;
   logic [DW-1:0] slv_dat      = '0;
   assign bus.wbd_ack_i = man_ack | (auto_ack & bus.wbd_stb_o);
   assign bus.wbd_err_i = man_err;
   assign bus.wbd_dat_i = dat_from_adr ? ~bus.wbd_adr_o : slv_dat;

   int errors = 0;
   int checks = 0;
   logic [NPORT-1:0] exp_q[$];

   task automatic set_port(input int p, input logic we, input logic [AW-1:0] adr,
                           input logic [DW-1:0] wd, input logic [SW-1:0] be);
      bus.cpu_we_i[p]               = we;
      bus.cpu_adr_i[p*AW +: AW]     = adr;
      bus.cpu_wdata_i[p*DW +: DW]   = wd;
      bus.cpu_be_i[p*SW +: SW]      = be;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      bus.cpu_req_i = '0;
      auto_ack = 1'b0;
      man_ack  = 1'b0;
      man_err  = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      bus.cpu_req_i   = '0;
      bus.cpu_we_i    = '0;
      bus.cpu_adr_i   = '0;
      bus.cpu_wdata_i = '0;
      bus.cpu_be_i    = '0;
      #1 rst_n = 1'b0;
      bus.cpu_req_i = 2'b11;
      @(negedge clk);
      @(negedge clk);
      checks++; if (bus.wbd_stb_o !== 1'b0) begin errors++; $display("FAIL rst_stb: got %0h exp 0", bus.wbd_stb_o); end
      checks++; if (bus.wbd_cyc_o !== 1'b0) begin errors++; $display("FAIL rst_cyc: got %0h exp 0", bus.wbd_cyc_o); end
      checks++; if (bus.cpu_req_ack_o !== 2'b00) begin errors++; $display("FAIL rst_req_ack: got %0h exp 0", bus.cpu_req_ack_o); end
      checks++; if (bus.cpu_resp_vld_o !== 2'b00) begin errors++; $display("FAIL rst_resp_vld: got %0h exp 0", bus.cpu_resp_vld_o); end
      checks++; if (bus.cpu_rdata_o !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %0h exp 0", bus.cpu_rdata_o); end
      checks++; if (bus.cpu_resp_err_o !== 1'b0) begin errors++; $display("FAIL rst_err: got %0h exp 0", bus.cpu_resp_err_o); end
      checks++; if (bus.tmo_evt_o !== 1'b0) begin errors++; $display("FAIL rst_tmo_evt: got %0h exp 0", bus.tmo_evt_o); end
      checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL rst_state: got %0d exp %0d", dbg_state, IDLE); end
      bus.cpu_req_i = '0;
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_read();
      @(posedge clk); #1;
      set_port(0, 1'b0, 32'h1000, 32'h0, 4'hF);
      slv_dat = 32'hDEADBEEF;
      dat_from_adr = 1'b0;
      auto_ack = 1'b1;
      bus.cpu_req_i = 2'b01;
      @(negedge clk); // T0
      checks++; if (bus.cpu_req_ack_o !== 2'b00) begin errors++; $display("FAIL rd_t0_ack: got %0h exp 0", bus.cpu_req_ack_o); end
      @(negedge clk); // T1
      checks++; if (bus.cpu_req_ack_o !== 2'b01) begin errors++; $display("FAIL rd_t1_ack: got %0h exp 1", bus.cpu_req_ack_o); end
      checks++; if (bus.wbd_stb_o !== 1'b1 || bus.wbd_cyc_o !== 1'b1) begin errors++; $display("FAIL rd_t1_stb: got stb=%0h cyc=%0h exp 1", bus.wbd_stb_o, bus.wbd_cyc_o); end
      checks++; if (bus.wbd_adr_o !== 32'h1000) begin errors++; $display("FAIL rd_adr: got %0h exp 1000", bus.wbd_adr_o); end
      checks++; if (bus.wbd_we_o !== 1'b0) begin errors++; $display("FAIL rd_we: got %0h exp 0", bus.wbd_we_o); end
      checks++; if (bus.cpu_resp_vld_o !== 2'b00) begin errors++; $display("FAIL rd_t1_vld: got %0h exp 0", bus.cpu_resp_vld_o); end
      @(posedge clk); #1 bus.cpu_req_i = '0;
      @(negedge clk); // T2
      checks++; if (bus.cpu_resp_vld_o !== 2'b01) begin errors++; $display("FAIL rd_t2_vld: got %0h exp 1", bus.cpu_resp_vld_o); end
      checks++; if (bus.cpu_rdata_o !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_rdata: got %0h exp deadbeef", bus.cpu_rdata_o); end
      checks++; if (bus.cpu_resp_err_o !== 1'b0) begin errors++; $display("FAIL rd_err: got %0h exp 0", bus.cpu_resp_err_o); end
      checks++; if (bus.wbd_stb_o !== 1'b0) begin errors++; $display("FAIL rd_t2_stb: got %0h exp 0", bus.wbd_stb_o); end
      @(negedge clk); // T3
      checks++; if (bus.cpu_resp_vld_o !== 2'b00) begin errors++; $display("FAIL rd_t3_vld: got %0h exp 0", bus.cpu_resp_vld_o); end
      checks++; if (bus.cpu_rdata_o !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_rdata_hold: got %0h exp deadbeef", bus.cpu_rdata_o); end
      checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL rd_t3_state: got %0d exp %0d", dbg_state, IDLE); end
      auto_ack = 1'b0;
   endtask

   task automatic test_round_robin();
      int grants = 0;
      int resps = 0;
      int ncyc = 0;
      int first_ack = 0;
      int last_resp = 0;
      logic [NPORT-1:0] exp_g;
      logic [NPORT-1:0] last_exp = '0;
      logic [DW-1:0] exp_rd;
      apply_reset();
      set_port(0, 1'b0, 32'h0000_0100, 32'h0, 4'hF);
      set_port(1, 1'b0, 32'h0000_0204, 32'h0, 4'hF);
      dat_from_adr = 1'b1;
      auto_ack = 1'b1;
      exp_q = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
      bus.cpu_req_i = 2'b11;
      while (resps < 8 && ncyc < 100) begin
         @(negedge clk);
         ncyc++;
         if (bus.cpu_req_ack_o !== 2'b00) begin
            if (grants == 0) first_ack = ncyc;
            exp_g = (exp_q.size() > 0) ? exp_q.pop_front() : 2'b00;
            checks++; if (bus.cpu_req_ack_o !== exp_g) begin errors++; $display("FAIL rr_grant%0d: got %0h exp %0h", grants, bus.cpu_req_ack_o, exp_g); end
            last_exp = exp_g;
            grants++;
            if (grants == 8) bus.cpu_req_i = '0;
         end
         if (bus.cpu_resp_vld_o !== 2'b00) begin
            exp_rd = (last_exp == 2'b01) ? ~32'h0000_0100 : ~32'h0000_0204;
            checks++; if (bus.cpu_resp_vld_o !== last_exp) begin errors++; $display("FAIL rr_resp%0d: got %0h exp %0h", resps, bus.cpu_resp_vld_o, last_exp); end
            checks++; if (bus.cpu_rdata_o !== exp_rd) begin errors++; $display("FAIL rr_rdata%0d: got %0h exp %0h", resps, bus.cpu_rdata_o, exp_rd); end
            resps++;
            last_resp = ncyc;
         end
      end
      checks++; if (resps != 8) begin errors++; $display("FAIL rr_resp_count: got %0d exp 8", resps); end
      checks++; if (last_resp - first_ack != 22) begin errors++; $display("FAIL rr_throughput: got %0d cycles exp 22", last_resp - first_ack); end
      auto_ack = 1'b0;
      dat_from_adr = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_write();
      slv_dat = 32'hCAFEF00D;
      set_port(1, 1'b1, 32'h2004, 32'h12345678, 4'b0011);
      @(posedge clk); #1 bus.cpu_req_i = 2'b10;
      @(negedge clk); // T0
      @(negedge clk); // T1
      checks++; if (bus.cpu_req_ack_o !== 2'b10) begin errors++; $display("FAIL wr_ack: got %0h exp 2", bus.cpu_req_ack_o); end
      checks++; if (bus.wbd_we_o !== 1'b1) begin errors++; $display("FAIL wr_we: got %0h exp 1", bus.wbd_we_o); end
      checks++; if (bus.wbd_adr_o !== 32'h2004) begin errors++; $display("FAIL wr_adr: got %0h exp 2004", bus.wbd_adr_o); end
      @(posedge clk); #1 bus.cpu_req_i = '0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++; if (bus.wbd_stb_o !== 1'b1) begin errors++; $display("FAIL wr_stb_hold%0d: got %0h exp 1", k, bus.wbd_stb_o); end
         checks++; if (bus.wbd_dat_o !== 32'h12345678) begin errors++; $display("FAIL wr_dat_hold%0d: got %0h exp 12345678", k, bus.wbd_dat_o); end
         checks++; if (bus.wbd_sel_o !== 4'b0011) begin errors++; $display("FAIL wr_sel_hold%0d: got %0h exp 3", k, bus.wbd_sel_o); end
      end
      @(posedge clk); #1 man_ack = 1'b1;
      @(negedge clk);
      checks++; if (bus.wbd_stb_o !== 1'b1) begin errors++; $display("FAIL wr_stb_at_ack: got %0h exp 1", bus.wbd_stb_o); end
      @(posedge clk); #1 man_ack = 1'b0;
      @(negedge clk);
      checks++; if (bus.cpu_resp_vld_o !== 2'b10) begin errors++; $display("FAIL wr_vld: got %0h exp 2", bus.cpu_resp_vld_o); end
      checks++; if (bus.cpu_rdata_o !== 32'h0) begin errors++; $display("FAIL wr_rdata: got %0h exp 0", bus.cpu_rdata_o); end
      checks++; if (bus.cpu_resp_err_o !== 1'b0) begin errors++; $display("FAIL wr_err: got %0h exp 0", bus.cpu_resp_err_o); end
      checks++; if (bus.wbd_stb_o !== 1'b0) begin errors++; $display("FAIL wr_stb_drop: got %0h exp 0", bus.wbd_stb_o); end
      @(negedge clk);
   endtask

   task automatic test_timeout();
      int stb_cycles = 0;
      int tmo_pulses = 0;
      int n = 0;
      bit done = 1'b0;
      set_port(0, 1'b0, 32'h3000, 32'h0, 4'hF);
      @(posedge clk); #1 bus.cpu_req_i = 2'b01;
      @(negedge clk); // T0
      while (!done && n < 40) begin
         @(negedge clk);
         n++;
         if (bus.cpu_req_ack_o[0]) bus.cpu_req_i[0] = 1'b0;
         if (bus.tmo_evt_o) tmo_pulses++;
         if (bus.wbd_stb_o) stb_cycles++;
         else if (stb_cycles > 0) begin
            done = 1'b1;
            checks++; if (bus.tmo_evt_o !== 1'b1) begin errors++; $display("FAIL tmo_evt: got %0h exp 1", bus.tmo_evt_o); end
            checks++; if (bus.cpu_resp_vld_o !== 2'b01) begin errors++; $display("FAIL tmo_vld: got %0h exp 1", bus.cpu_resp_vld_o); end
            checks++; if (bus.cpu_resp_err_o !== 1'b1) begin errors++; $display("FAIL tmo_err: got %0h exp 1", bus.cpu_resp_err_o); end
            checks++; if (bus.cpu_rdata_o !== 32'h0) begin errors++; $display("FAIL tmo_rdata: got %0h exp 0", bus.cpu_rdata_o); end
         end
      end
      checks++; if (!done) begin errors++; $display("FAIL tmo_no_drop: got stb still high after %0d cycles exp drop", n); end
      checks++; if (stb_cycles != TMO) begin errors++; $display("FAIL tmo_bus_cycles: got %0d exp %0d", stb_cycles, TMO); end
      @(negedge clk);
      if (bus.tmo_evt_o) tmo_pulses++;
      checks++; if (tmo_pulses != 1) begin errors++; $display("FAIL tmo_pulse_count: got %0d exp 1", tmo_pulses); end
      checks++; if (bus.cpu_resp_vld_o !== 2'b00) begin errors++; $display("FAIL tmo_vld_after: got %0h exp 0", bus.cpu_resp_vld_o); end
   endtask

   task automatic test_ack_err();
      slv_dat = 32'h0000_0055;
      set_port(1, 1'b0, 32'h4000, 32'h0, 4'hF);
      @(posedge clk); #1 bus.cpu_req_i = 2'b10;
      @(negedge clk); // T0
      @(posedge clk); #1 man_ack = 1'b1; man_err = 1'b1;
      @(negedge clk); // T1
      checks++; if (bus.cpu_req_ack_o !== 2'b10) begin errors++; $display("FAIL ae_ack: got %0h exp 2", bus.cpu_req_ack_o); end
      @(posedge clk); #1 man_ack = 1'b0; man_err = 1'b0; bus.cpu_req_i = '0;
      @(negedge clk); // T2
      checks++; if (bus.cpu_resp_vld_o !== 2'b10) begin errors++; $display("FAIL ae_vld: got %0h exp 2", bus.cpu_resp_vld_o); end
      checks++; if (bus.cpu_resp_err_o !== 1'b1) begin errors++; $display("FAIL ae_err: got %0h exp 1", bus.cpu_resp_err_o); end
      checks++; if (bus.cpu_rdata_o !== 32'h0) begin errors++; $display("FAIL ae_rdata: got %0h exp 0", bus.cpu_rdata_o); end
      @(posedge clk); #1 man_ack = 1'b1; // stray ack while IDLE
      @(posedge clk); #1 man_ack = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         checks++; if (bus.cpu_resp_vld_o !== 2'b00) begin errors++; $display("FAIL stray_vld%0d: got %0h exp 0", k, bus.cpu_resp_vld_o); end
         checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL stray_state%0d: got %0d exp %0d", k, dbg_state, IDLE); end
         checks++; if (bus.wbd_stb_o !== 1'b0) begin errors++; $display("FAIL stray_stb%0d: got %0h exp 0", k, bus.wbd_stb_o); end
      end
      checks++; if (bus.cpu_resp_err_o !== 1'b1) begin errors++; $display("FAIL ae_err_hold: got %0h exp 1", bus.cpu_resp_err_o); end
   endtask

   task automatic test_reset_mid();
      set_port(1, 1'b0, 32'h5000, 32'h0, 4'hF);
      @(posedge clk); #1 bus.cpu_req_i = 2'b10;
      @(negedge clk); // T0
      @(negedge clk); // T1
      checks++; if (bus.wbd_stb_o !== 1'b1) begin errors++; $display("FAIL rm_pre_stb: got %0h exp 1", bus.wbd_stb_o); end
      @(negedge clk); // T2, still waiting on the slave
      #2 rst_n = 1'b0;
      #1;
      checks++; if (bus.wbd_stb_o !== 1'b0 || bus.wbd_cyc_o !== 1'b0) begin errors++; $display("FAIL rm_drop: got stb=%0h cyc=%0h exp 0", bus.wbd_stb_o, bus.wbd_cyc_o); end
      checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL rm_state: got %0d exp %0d", dbg_state, IDLE); end
      bus.cpu_req_i = '0;
      repeat (2) begin
         @(negedge clk);
         checks++; if (bus.cpu_resp_vld_o !== 2'b00) begin errors++; $display("FAIL rm_no_resp: got %0h exp 0", bus.cpu_resp_vld_o); end
      end
      @(posedge clk); #1 rst_n = 1'b1;
      dat_from_adr = 1'b1;
      auto_ack = 1'b1;
      set_port(0, 1'b0, 32'h0000_0600, 32'h0, 4'hF);
      bus.cpu_req_i = 2'b11;
      @(negedge clk); // T0
      checks++; if (bus.cpu_req_ack_o !== 2'b00) begin errors++; $display("FAIL rm_t0_ack: got %0h exp 0", bus.cpu_req_ack_o); end
      @(negedge clk); // T1
      checks++; if (bus.cpu_req_ack_o !== 2'b01) begin errors++; $display("FAIL rm_first_grant: got %0h exp 1", bus.cpu_req_ack_o); end
      checks++; if (bus.wbd_adr_o !== 32'h0000_0600) begin errors++; $display("FAIL rm_adr: got %0h exp 600", bus.wbd_adr_o); end
      @(posedge clk); #1 bus.cpu_req_i = 2'b10;
      @(negedge clk); // T2
      checks++; if (bus.cpu_resp_vld_o !== 2'b01) begin errors++; $display("FAIL rm_vld: got %0h exp 1", bus.cpu_resp_vld_o); end
      checks++; if (bus.cpu_rdata_o !== 32'hFFFF_F9FF) begin errors++; $display("FAIL rm_rdata: got %0h exp fffff9ff", bus.cpu_rdata_o); end
      checks++; if (bus.cpu_resp_err_o !== 1'b0) begin errors++; $display("FAIL rm_err: got %0h exp 0", bus.cpu_resp_err_o); end
      @(posedge clk); #1 bus.cpu_req_i = '0;
      auto_ack = 1'b0;
      dat_from_adr = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_read();
      test_round_robin();
      test_write();
      test_timeout();
      test_ack_err();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test exp finish before 200000");
      $fatal(1, "watchdog expired");
   end

endmodule
